// File: rtl/booth_mult_pkg.sv
// booth_mult_pkg: shared types and constants for the booth_mult slice.
//   state_e     - FSM states of the sequential Booth multiplier
//   TEMP_*      - bit positions inside the 6-bit temp status bus
package booth_mult_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned TEMP_CNT_LSB = 0;
    localparam int unsigned TEMP_BUSY    = 4;
    localparam int unsigned TEMP_DONE    = 5;

endpackage : booth_mult_pkg

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth iteration.
//   Recodes {q_i[0], q1_i}, adds/subtracts the multiplicand, then performs
//   the arithmetic right shift of {acc, Q, q_1}.
// Ports:
//   acc_i [WIDTH-1:0]  accumulator (signed)
//   q_i   [WIDTH-1:0]  multiplier / low product bits
//   q1_i               extra bit to the right of Q
//   m_i   [WIDTH-1:0]  multiplicand (signed)
//   acc_o, q_o, q1_o   shifted next values
module booth_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q1_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q1_o
);

    logic [WIDTH:0] acc_x;
    logic [WIDTH:0] m_x;
    logic [WIDTH:0] sum;

    // The add/sub is carried one bit wider so the shift replicates the true
    // sign. A plain WIDTH-bit wrap would flip the sign of -2^(W-1) * -2^(W-1);
    // the shifted accumulator always fits back into WIDTH bits.
    always_comb begin
        acc_x = {acc_i[WIDTH-1], acc_i};
        m_x   = {m_i[WIDTH-1], m_i};
        unique case ({q_i[0], q1_i})
            2'b01:   sum = acc_x + m_x;
            2'b10:   sum = acc_x - m_x;
            default: sum = acc_x;
        endcase
    end

    assign acc_o = sum[WIDTH:1];
    assign q_o   = {sum[0], q_i[WIDTH-1:1]};
    assign q1_o  = q_i[0];

endmodule : booth_step

// File: rtl/booth_mult.sv
// booth_mult: free-running sequential radix-2 Booth multiplier.
//   LOAD samples A/B, ITER runs WIDTH Booth steps, DONE publishes Z, then
//   the cycle repeats (period WIDTH+2 clocks). No handshake.
// Ports:
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   A    [WIDTH-1:0]  multiplicand, signed
//   B    [WIDTH-1:0]  multiplier, signed
//   Z    [2W-1:0]     registered signed product of the last operation
//   temp [5:0]        status: [3:0] iteration count, [4] busy, [5] done
// Configuration:
//   BOOTH_MULT_STATUS_EN  defined: temp carries status; undefined: temp = 0.
module booth_mult
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   Z,
    output logic [5:0]           temp
);

    localparam int CNT_W = ($clog2(WIDTH + 1) < 4) ? 4 : $clog2(WIDTH + 1);

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      m_q,     m_d;
    logic [WIDTH-1:0]      acc_q,   acc_d;
    logic [WIDTH-1:0]      q_q,     q_d;
    logic                  q1_q,    q1_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [2*WIDTH-1:0]    z_q,     z_d;

    logic [WIDTH-1:0]      step_acc;
    logic [WIDTH-1:0]      step_q;
    logic                  step_q1;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i (acc_q),
        .q_i   (q_q),
        .q1_i  (q1_q),
        .m_i   (m_q),
        .acc_o (step_acc),
        .q_o   (step_q),
        .q1_o  (step_q1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        unique case (state_q)
            LOAD: begin
                m_d     = A;
                acc_d   = '0;
                q_d     = B;
                q1_d    = 1'b0;
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
                acc_d = step_acc;
                q_d   = step_q;
                q1_d  = step_q1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_W'(WIDTH)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                z_d     = {acc_q, q_q};
                // Cleared here so the count reads 0 throughout LOAD.
                cnt_d   = '0;
                state_d = LOAD;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign Z = z_q;

`ifdef BOOTH_MULT_STATUS_EN
    logic [31:0] cnt_ext;

    always_comb begin
        temp    = '0;
        cnt_ext = 32'(cnt_q);
        temp[TEMP_CNT_LSB +: 4] = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];
        temp[TEMP_BUSY]         = (state_q == ITER);
        temp[TEMP_DONE]         = (state_q == DONE);
    end
`else
    assign temp = '0;
`endif

endmodule : booth_mult

// File: tb/tb_booth_mult.sv
// tb_booth_mult: directed self-checking bench for booth_mult (WIDTH=8).
module tb_booth_mult;

`ifdef BOOTH_MULT_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] Z;
    logic [5:0]  temp;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    booth_mult #(
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Z     (Z),
        .temp  (temp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [5:0] st(input logic [5:0] v);
        return STATUS ? v : 6'h00;
    endfunction

    // Called at a negedge while the DUT sits in LOAD; returns at the
    // negedge after the DONE edge (DUT back in LOAD, Z updated).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input string tag);
        A = a;
        B = b;
        tick(10);
        check(tag, 32'(Z), 32'(exp));
    endtask

    initial begin
        int unsigned pulses;
        int unsigned z_bad;

        rst_n = 1'b0;
        A     = 8'h12;
        B     = 8'h34;
        tick(5);
        check("reset_Z", 32'(Z), 32'h0000);
        check("reset_temp", 32'(temp), 32'h00);

        // Release at a negedge: next posedge is the first LOAD edge.
        rst_n = 1'b1;
        check("load_temp", 32'(temp), 32'(st(6'h00)));
        tick(1);
        check("iter0_temp", 32'(temp), 32'(st(6'h10)));
        tick(8);
        check("done_temp", 32'(temp), 32'(st(6'h28)));
        check("pre_done_Z", 32'(Z), 32'h0000);
        tick(1);
        check("first_Z", 32'(Z), 32'h03A8);
        check("reload_temp", 32'(temp), 32'(st(6'h00)));

        run_op(8'hFF, 8'hFF, 16'h0001, "m1_x_m1");
        pulses = 0;
        z_bad  = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (temp[5]) pulses++;
            if (Z !== 16'h0001) z_bad++;
        end
        check("m1_Z_stable", z_bad, 0);
        check("done_pulses", pulses, STATUS ? 2 : 0);

        run_op(8'h80, 8'h80, 16'h4000, "min_x_min");
        run_op(8'h7F, 8'h80, 16'hC080, "max_x_min");
        run_op(8'h03, 8'hFE, 16'hFFFA, "3_x_m2");
        run_op(8'h00, 8'h5A, 16'h0000, "0_x_5a");
        run_op(8'h81, 8'h7F, 16'hC0FF, "m127_x_127");

        // Operand change during ITER is ignored until the next LOAD.
        A = 8'h05;
        B = 8'h02;
        tick(3);
        A = 8'h07;
        tick(7);
        check("a_change_cur", 32'(Z), 32'h000A);
        tick(10);
        check("a_change_next", 32'(Z), 32'h000E);

        // Asynchronous reset in the middle of ITER (cnt=4).
        A = 8'h12;
        B = 8'h34;
        tick(5);
        check("iter4_temp", 32'(temp), 32'(st(6'h14)));
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_Z", 32'(Z), 32'h0000);
        check("abort_temp", 32'(temp), 32'h00);
        tick(2);
        rst_n = 1'b1;
        A = 8'h03;
        B = 8'h05;
        tick(9);
        check("restart_pre_Z", 32'(Z), 32'h0000);
        tick(1);
        check("restart_Z", 32'(Z), 32'h000F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_booth_mult
